yutorina_bus_if: RTL

Memory-access front end used twice per core: once for the IF stage (instruction side) and once for the MEM stage (data side). It takes a pipeline-stage access request and routes it by address to one of two places. Accesses to the scratch-pad memory (yutorina_spm) complete in one cycle. All other accesses become an arbitrated external-bus transaction (req_/grnt_/as_/rdy_), and the block raises busy until that transaction completes. It sits between the pipeline stage and the SPM port / external bus master interface.

---
 rtl/yutorina_bus_if_pkg.sv | 19 +
 rtl/yutorina_bus_if_if.sv | 24 ++
 rtl/yutorina_bus_if.sv | 138 +++++++++++++
 3 files changed

// File: rtl/yutorina_bus_if_pkg.sv
// Shared definitions for the yutorina memory-access front end: FSM states,
// access direction encodings and the bus slave index used to pick the SPM.
package yutorina_bus_if_pkg;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'h0,
        BUS_IF_STATE_REQ    = 2'h1,
        BUS_IF_STATE_ACCESS = 2'h2,
        BUS_IF_STATE_STALL  = 2'h3
    } bus_if_state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Slave index is the top three bits of a word address.
    typedef logic [2:0] bus_slave_index_t;
    localparam bus_slave_index_t BUS_SLAVE_IDX_SPM = 3'h1;

endpackage

// File: rtl/yutorina_bus_if_if.sv
// External bus master/slave signal bundle (arbitrated, active-low handshakes).
interface yutorina_bus_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] bus_r_data;
    logic              bus_rdy_;
    logic              bus_grnt_;
    logic              bus_req_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_w_data;

    modport master (
        input  bus_r_data, bus_rdy_, bus_grnt_,
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_w_data
    );

    modport slave (
        output bus_r_data, bus_rdy_, bus_grnt_,
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_w_data
    );
endinterface

// File: rtl/yutorina_bus_if.sv
// Pipeline-stage memory front end: zero-latency scratch-pad accesses, all other
// addresses become an arbitrated external bus transaction that holds busy high.
module yutorina_bus_if
    import yutorina_bus_if_pkg::*;
#(
    parameter int               ADDR_W     = 30,
    parameter int               DATA_W     = 32,
    parameter int               SPM_ADDR_W = 12,
    parameter bus_slave_index_t SPM_INDEX  = BUS_SLAVE_IDX_SPM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  busy,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [DATA_W-1:0]     w_data,
    output logic [DATA_W-1:0]     r_data,
    input  logic [DATA_W-1:0]     spm_r_data,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [DATA_W-1:0]     spm_w_data,
    yutorina_bus_if_if.master     bus
);

    bus_if_state_e     state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_rw_q, bus_rw_d;
    logic [DATA_W-1:0] bus_w_data_q, bus_w_data_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic              spm_sel;
    logic              access_valid;

    assign spm_sel      = (addr[ADDR_W-1 -: 3] == SPM_INDEX);
    assign access_valid = !flush && !as_;

    assign spm_addr   = addr[SPM_ADDR_W-1:0];
    assign spm_rw     = rw;
    assign spm_w_data = w_data;

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_as_d     = bus_as_q;
        bus_addr_d   = bus_addr_q;
        bus_rw_d     = bus_rw_q;
        bus_w_data_d = bus_w_data_q;
        rd_buf_d     = rd_buf_q;
        busy         = 1'b0;
        r_data       = '0;
        spm_as_      = 1'b1;

        unique case (state_q)
            BUS_IF_STATE_IDLE: begin
                if (access_valid) begin
                    if (spm_sel) begin
                        spm_as_ = 1'b0;
                        if (!stall) begin
                            r_data = spm_r_data;
                        end
                    end else begin
                        busy         = 1'b1;
                        state_d      = BUS_IF_STATE_REQ;
                        bus_req_d    = 1'b0;
                        bus_addr_d   = addr;
                        bus_rw_d     = rw;
                        bus_w_data_d = w_data;
                    end
                end
            end
            BUS_IF_STATE_REQ: begin
                busy = 1'b1;
                if (!bus.bus_grnt_) begin
                    state_d  = BUS_IF_STATE_ACCESS;
                    bus_as_d = 1'b0;
                end
            end
            BUS_IF_STATE_ACCESS: begin
                // The strobe is a single-cycle pulse; the request stays low until ready.
                bus_as_d = 1'b1;
                if (!bus.bus_rdy_) begin
                    r_data       = bus.bus_r_data;
                    bus_req_d    = 1'b1;
                    bus_addr_d   = '0;
                    bus_rw_d     = READ;
                    bus_w_data_d = '0;
                    if (bus_rw_q == READ) begin
                        rd_buf_d = bus.bus_r_data;
                    end
                    state_d = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            BUS_IF_STATE_STALL: begin
                r_data = rd_buf_q;
                if (!stall) begin
                    state_d = BUS_IF_STATE_IDLE;
                end
            end
            default: begin
                state_d = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BUS_IF_STATE_IDLE;
            bus_req_q    <= 1'b1;
            bus_as_q     <= 1'b1;
            bus_addr_q   <= '0;
            bus_rw_q     <= READ;
            bus_w_data_q <= '0;
            rd_buf_q     <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_as_q     <= bus_as_d;
            bus_addr_q   <= bus_addr_d;
            bus_rw_q     <= bus_rw_d;
            bus_w_data_q <= bus_w_data_d;
            rd_buf_q     <= rd_buf_d;
        end
    end

    assign bus.bus_req_   = bus_req_q;
    assign bus.bus_as_    = bus_as_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_rw     = bus_rw_q;
    assign bus.bus_w_data = bus_w_data_q;

endmodule
